// File: rtl/code_sequencer.sv
// Program store and sequencer: holds control words, presents the word at pc,
// and advances pc on step with absolute jumps and a nested counted-loop stack.
module code_sequencer #(
  parameter int CODE_W     = 12,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int LOOP_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             step,
  input  logic                             jump,
  input  logic [ADDR_W-1:0]                jump_addr,
  input  logic                             loop_end,
  input  logic                             loop_push,
  input  logic [ADDR_W-1:0]                loop_start,
  input  logic [CNT_W-1:0]                 loop_count,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [CODE_W-1:0]                wr_data,
  output logic [CODE_W-1:0]                code,
  output logic [ADDR_W-1:0]                pc,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]  loop_level,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int LW = $clog2(LOOP_DEPTH + 1);
  localparam int SW = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  logic [CODE_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LW-1:0]     level_q, level_d;
  logic [ADDR_W-1:0] start_q [LOOP_DEPTH];
  logic [ADDR_W-1:0] start_d [LOOP_DEPTH];
  logic [CNT_W-1:0]  rem_q   [LOOP_DEPTH];
  logic [CNT_W-1:0]  rem_d   [LOOP_DEPTH];
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [SW-1:0]     top_idx;
  logic [SW-1:0]     push_idx;
  logic              do_step;
  logic              do_push;

  assign do_step = enable && step;
  assign do_push = enable && loop_push;
  assign top_idx = SW'(level_q - LW'(1));

  // NOTE: program memory has no reset; it is loaded through the write port and
  // must keep its contents across a sequencer reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    pc_d     = pc_q;
    level_d  = level_q;
    start_d  = start_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push_idx = '0;

    if (do_step) begin
      if (jump) begin
        pc_d = jump_addr;
      end else if (loop_end) begin
        if (level_q == '0) begin
          unf_d = 1'b1;
          pc_d  = pc_q + ADDR_W'(1);
        end else if (rem_q[top_idx] != '0) begin
          pc_d           = start_q[top_idx];
          rem_d[top_idx] = rem_q[top_idx] - CNT_W'(1);
        end else begin
          level_d = level_q - LW'(1);
          pc_d    = pc_q + ADDR_W'(1);
        end
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end

    // Push sees the post-pop stack, so a full stack that pops this cycle accepts it.
    if (do_push) begin
      if (level_d == LW'(LOOP_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        push_idx          = SW'(level_d);
        start_d[push_idx] = loop_start;
        rem_d[push_idx]   = loop_count;
        level_d           = level_d + LW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack entries above loop_level are dead, so clearing level alone empties it.
  always_ff @(posedge clk) begin
    start_q <= start_d;
    rem_q   <= rem_d;
  end

  always_comb begin
    if (!enable) begin
      code = '0;
    end else if (wr_en && (wr_addr == pc_q)) begin
      code = wr_data;
    end else begin
      code = mem[pc_q];
    end
  end

  assign pc         = pc_q;
  assign loop_level = level_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_code_sequencer.sv
// Directed bench for code_sequencer: a DEPTH=4 instance for load/wrap and a
// default instance for loops, error flags, priority, forwarding and enable.
module tb_code_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, st, jp, le, lp, we;
  logic [6:0]  ja, ls, wa;
  logic [15:0] lc;
  logic [11:0] wd;

  logic [11:0] code_m, code_s;
  logic [6:0]  pc_m;
  logic [1:0]  pc_s;
  logic [2:0]  lvl_m, lvl_s;
  logic        ovf_m, unf_m, ovf_s, unf_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  code_sequencer dut (
    .clk(clk), .reset(rst), .enable(en), .step(st), .jump(jp), .jump_addr(ja),
    .loop_end(le), .loop_push(lp), .loop_start(ls), .loop_count(lc),
    .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .code(code_m), .pc(pc_m), .loop_level(lvl_m), .overflow(ovf_m), .underflow(unf_m)
  );

  code_sequencer #(.DEPTH(4)) u_small (
    .clk(clk), .reset(rst), .enable(en), .step(st), .jump(jp), .jump_addr(ja[1:0]),
    .loop_end(le), .loop_push(lp), .loop_start(ls[1:0]), .loop_count(lc),
    .wr_en(we), .wr_addr(wa[1:0]), .wr_data(wd),
    .code(code_s), .pc(pc_s), .loop_level(lvl_s), .overflow(ovf_s), .underflow(unf_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    st = 1'b0; jp = 1'b0; le = 1'b0; lp = 1'b0; we = 1'b0;
  endtask

  // One effective step with optional jump / push / loop_end, then check pc and level.
  task automatic vec(input string tag, input logic j, input int a, input logic p,
                     input int s, input int c, input logic e,
                     input int exp_pc, input int exp_lvl);
    st = 1'b1; jp = j; ja = 7'(a); lp = p; ls = 7'(s); lc = 16'(c); le = e;
    tick();
    clr();
    check({tag, ".pc"}, 32'(pc_m), exp_pc);
    check({tag, ".lvl"}, 32'(lvl_m), exp_lvl);
  endtask

  task automatic push_only(input int s, input int c);
    lp = 1'b1; ls = 7'(s); lc = 16'(c);
    tick();
    clr();
  endtask

  initial begin
    en = 1'b1; rst = 1'b1; ja = '0; ls = '0; lc = '0; wa = '0; wd = '0;
    clr();

    // Program load during reset cycles, then release.
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; wa = 7'(i); wd = 12'h101 + 12'(i);
      tick();
    end
    we = 1'b0;
    tick();
    rst = 1'b0;
    check("rst.pc", 32'(pc_s), 0);
    check("rst.lvl", 32'(lvl_s), 0);
    check("rst.ovf", 32'(ovf_s), 0);
    check("rst.unf", 32'(unf_s), 0);
    check("rst.code", 32'(code_s), 32'h101);

    // Load-and-run on the DEPTH=4 instance, wrapping back to line 0.
    for (int i = 1; i <= 4; i++) begin
      st = 1'b1;
      tick();
      clr();
      check("run.code", 32'(code_s), (i == 4) ? 32'h101 : 32'h101 + 32'(i));
    end
    check("run.wrap_pc", 32'(pc_s), 0);

    // Simple loop: body 2..4 runs three times.
    vec("sl.jmp", 1, 2, 0, 0, 0, 0, 2, 0);
    vec("sl0", 0, 0, 1, 2, 2, 0, 3, 1);
    vec("sl1", 0, 0, 0, 0, 0, 0, 4, 1);
    vec("sl2", 0, 0, 0, 0, 0, 1, 2, 1);
    vec("sl3", 0, 0, 0, 0, 0, 0, 3, 1);
    vec("sl4", 0, 0, 0, 0, 0, 0, 4, 1);
    vec("sl5", 0, 0, 0, 0, 0, 1, 2, 1);
    vec("sl6", 0, 0, 0, 0, 0, 0, 3, 1);
    vec("sl7", 0, 0, 0, 0, 0, 0, 4, 1);
    vec("sl8", 0, 0, 0, 0, 0, 1, 5, 0);

    // Nested loops: outer 1..4 twice, inner 2..3 twice per outer pass.
    vec("nl.jmp", 1, 1, 0, 0, 0, 0, 1, 0);
    vec("nl0", 0, 0, 1, 1, 1, 0, 2, 1);
    vec("nl1", 0, 0, 1, 2, 1, 0, 3, 2);
    vec("nl2", 0, 0, 0, 0, 0, 1, 2, 2);
    vec("nl3", 0, 0, 0, 0, 0, 0, 3, 2);
    vec("nl4", 0, 0, 0, 0, 0, 1, 4, 1);
    vec("nl5", 0, 0, 0, 0, 0, 1, 1, 1);
    vec("nl6", 0, 0, 0, 0, 0, 0, 2, 1);
    vec("nl7", 0, 0, 1, 2, 1, 0, 3, 2);
    vec("nl8", 0, 0, 0, 0, 0, 1, 2, 2);
    vec("nl9", 0, 0, 0, 0, 0, 0, 3, 2);
    vec("nl10", 0, 0, 0, 0, 0, 1, 4, 1);
    vec("nl11", 0, 0, 0, 0, 0, 1, 5, 0);

    // Underflow, then overflow on the fifth push.
    vec("uf", 0, 0, 0, 0, 0, 1, 6, 0);
    check("uf.flag", 32'(unf_m), 1);
    check("uf.ovf", 32'(ovf_m), 0);
    for (int i = 0; i < 4; i++) push_only(0, 0);
    check("full.lvl", 32'(lvl_m), 4);
    check("full.ovf", 32'(ovf_m), 0);
    push_only(0, 0);
    check("of.lvl", 32'(lvl_m), 4);
    check("of.flag", 32'(ovf_m), 1);

    // Pop and push in one cycle on a full stack: push lands on the freed slot.
    vec("popush", 0, 0, 1, 50, 1, 1, 7, 4);
    vec("popush.e1", 0, 0, 0, 0, 0, 1, 50, 4);
    vec("popush.e2", 0, 0, 0, 0, 0, 1, 51, 3);
    check("sticky.ovf", 32'(ovf_m), 1);
    check("sticky.unf", 32'(unf_m), 1);

    // Reset mid-loop beats step, push and loop_end.
    rst = 1'b1; st = 1'b1; le = 1'b1; lp = 1'b1;
    tick();
    rst = 1'b0;
    clr();
    check("mrst.pc", 32'(pc_m), 0);
    check("mrst.lvl", 32'(lvl_m), 0);
    check("mrst.ovf", 32'(ovf_m), 0);
    check("mrst.unf", 32'(unf_m), 0);

    // Jump beats loop_end; remaining count 3 survives (three returns, then pop).
    push_only(10, 3);
    check("pri.push", 32'(lvl_m), 1);
    vec("pri.jmp", 1, 20, 0, 0, 0, 1, 20, 1);
    vec("pri.e1", 0, 0, 0, 0, 0, 1, 10, 1);
    vec("pri.e2", 0, 0, 0, 0, 0, 1, 10, 1);
    vec("pri.e3", 0, 0, 0, 0, 0, 1, 10, 1);
    vec("pri.e4", 0, 0, 0, 0, 0, 1, 11, 0);

    // Forwarding of a write to the current line.
    we = 1'b1; wa = 7'd11; wd = 12'hABC;
    #1;
    check("fwd.code", 32'(code_m), 32'hABC);

    // Write to pc+1 during the step cycle appears via memory next cycle.
    wa = 7'd12; wd = 12'h5A5; st = 1'b1;
    tick();
    clr();
    check("nxt.pc", 32'(pc_m), 12);
    check("nxt.code", 32'(code_m), 32'h5A5);

    // Disabled: code forced to zero, step / push / loop_end ignored.
    en = 1'b0;
    #1;
    check("dis.code", 32'(code_m), 0);
    st = 1'b1; lp = 1'b1; le = 1'b1; ls = 7'd3; lc = 16'd5;
    tick();
    clr();
    check("dis.pc", 32'(pc_m), 12);
    check("dis.lvl", 32'(lvl_m), 0);
    check("dis.unf", 32'(unf_m), 0);
    en = 1'b1;
    #1;
    check("ena.code", 32'(code_m), 32'h5A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
